i2c_master: RTL and testbench



---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_sda_drv.sv | 11 +
 rtl/i2c_master.sv | 120 ++++++++++++
 tb/tb_i2c_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: FSM state encoding
// and bit-timing constants.
package i2c_pkg;

    typedef enum logic [7:0] {
        IDLE     = 8'd0,
        START    = 8'd1,
        ADDR     = 8'd2,
        RW       = 8'd3,
        ADDR_ACK = 8'd4,
        DATA     = 8'd5,
        DATA_ACK = 8'd6,
        STOP     = 8'd7
    } state_t;

    localparam int unsigned BIT_CYCLES = 2;
    localparam logic [2:0]  ADDR_LAST  = 3'd6;
    localparam logic [2:0]  DATA_LAST  = 3'd7;

endpackage

// File: rtl/i2c_sda_drv.sv
// Open-drain SDA pad: drives only 0 or Z, and returns the resolved line level.
module i2c_sda_drv (
    input  logic oe,
    inout  wire  sda,
    output logic din
);

    assign sda = oe ? 1'b0 : 1'bz;
    assign din = sda;

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller: one START/addr/RW/ACK/byte/ACK/STOP
// transaction per accepted start request, SCL at clk/2.
module i2c_master
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       rw,
    inout  wire        sda,
    output logic       scl,
    output logic       ready
);

    state_t     state, state_nx;
    logic       ph;
    logic [2:0] cnt;
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic       rw_q;
    logic [7:0] rdata;
    logic       ack_err;
    logic       oe;
    logic       din;
    logic       bit_end;

    i2c_sda_drv u_drv (
        .oe  (oe),
        .sda (sda),
        .din (din)
    );

    // The last clk of every bit period is the one with SCL high.
    assign bit_end = (state != IDLE) && (ph == 1'(BIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ph      <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            rdata   <= '0;
            ack_err <= 1'b0;
        end else begin
            state <= state_nx;
            ph    <= (state == IDLE) ? 1'b0 : ~ph;

            if (state_nx != state)
                cnt <= '0;
            else if (bit_end)
                cnt <= cnt + 3'd1;

            if (state == IDLE && start) begin
                addr_q  <= addr;
                data_q  <= data;
                rw_q    <= rw;
                ack_err <= 1'b0;
            end

            if (bit_end) begin
                case (state)
                    ADDR_ACK: if (cnt == '0 && din) ack_err <= 1'b1;
                    DATA:     if (rw_q) rdata <= {rdata[6:0], din};
                    DATA_ACK: if (!rw_q && din) ack_err <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = START;
            START:    if (bit_end) state_nx = ADDR;
            ADDR:     if (bit_end && cnt == ADDR_LAST) state_nx = RW;
            RW:       if (bit_end) state_nx = ADDR_ACK;
            // An address NACK spends one extra bit slot with SCL held low
            // before STOP, giving the 24-cycle NACK transaction length.
            ADDR_ACK: if (bit_end) begin
                          if (cnt != '0)
                              state_nx = STOP;
                          else if (!din)
                              state_nx = DATA;
                      end
            DATA:     if (bit_end && cnt == DATA_LAST) state_nx = DATA_ACK;
            DATA_ACK: if (bit_end) state_nx = STOP;
            STOP:     if (bit_end) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        scl   = ph;
        oe    = 1'b0;
        ready = 1'b0;
        case (state)
            IDLE: begin
                scl   = 1'b1;
                ready = 1'b1;
            end
            START: begin
                scl = 1'b1;
                oe  = ph;
            end
            ADDR:     oe = ~addr_q[ADDR_LAST - cnt];
            RW:       oe = ~rw_q;
            ADDR_ACK: if (cnt != '0) scl = 1'b0;
            DATA:     oe = ~rw_q & ~data_q[DATA_LAST - cnt];
            DATA_ACK: oe = 1'b0;
            STOP:     oe = 1'b1;
            default:  scl = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// Randomized scoreboard bench for i2c_master with a bus-level slave model.
module tb_i2c_master;

    logic       clk, rst, start, rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic       scl, ready;
    wire        sda;
    logic       slv_oe;

    assign sda = slv_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master i2c (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .addr  (addr),
        .data  (data),
        .rw    (rw),
        .sda   (sda),
        .scl   (scl),
        .ready (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          lat;
        logic        ackerr;
        logic [7:0]  rdata;
        logic        dseen;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Slave behaviour for the current transaction.
    logic       s_acka, s_ackd, s_rw;
    logic [7:0] s_rb;
    logic [7:0] m_rdata;
    logic       abort;

    // Whether the slave pulls SDA low for bus bit k (k counts SCL rises since START).
    function automatic logic want(input int k);
        if (k == 8) return s_acka;
        if (k >= 9 && k <= 16 && s_rw && s_acka) return ~s_rb[16 - k];
        if (k == 17 && !s_rw && s_acka && s_ackd) return 1'b1;
        return 1'b0;
    endfunction

    // Bus observer and slave.
    logic [31:0] bbits;
    int nbits, nrise, n_start, n_stop, contention;
    logic pscl, psda;

    initial begin
        bbits = '0; nbits = 0; nrise = 0; n_start = 0; n_stop = 0; contention = 0;
        pscl = 1'b1; psda = 1'b1; slv_oe = 1'b0;
        forever begin
            @(negedge clk);
            if ($isunknown(sda)) contention++;
            if (pscl && scl && psda !== sda) begin
                if (sda === 1'b0) begin
                    n_start++;
                    nrise = 0;
                    nbits = 0;
                    bbits = '0;
                end else begin
                    n_stop++;
                end
            end
            if (!pscl && scl) begin
                bbits = {bbits[30:0], sda};
                nbits++;
                nrise++;
            end
            if (!rst) slv_oe = 1'b0;
            else if (!scl) slv_oe = want(nrise);
            pscl = scl;
            psda = sda;
        end
    end

    // Monitor: pops the expectation once a transaction returns to ready.
    initial begin : monitor
        logic pr, busy, pend, dseen;
        int lat;
        exp_t e;
        pr = 1'b1; busy = 1'b0; pend = 1'b0; dseen = 1'b0; lat = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                end else if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txn got=1 expected=0");
                end else begin
                    e = q.pop_front();
                    check("bus_bits", bbits, e.bits);
                    check("bus_nbits", nbits, e.nbits);
                    check("latency", lat, e.lat);
                    check("ack_err", {31'd0, i2c.ack_err}, {31'd0, e.ackerr});
                    check("rdata", {24'd0, i2c.rdata}, {24'd0, e.rdata});
                    check("data_state_seen", {31'd0, dseen}, {31'd0, e.dseen});
                    check("start_conds", n_start, 1);
                    check("stop_conds", n_stop, 1);
                end
            end
            if (busy) begin
                if (ready) begin
                    busy = 1'b0;
                    pend = 1'b1;
                end else begin
                    lat++;
                    if (i2c.state == 8'd5) dseen = 1'b1;
                end
            end else if (pr && !ready) begin
                busy = 1'b1;
                lat = 1;
                dseen = (i2c.state == 8'd5);
                n_start = 0;
                n_stop = 0;
            end
            pr = ready;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=0 expected=1");
        end
    endtask

    task automatic txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                       input logic acka, input logic ackd, input logic [7:0] rb, input logic mid);
        exp_t e;
        e.bits = '0;
        e.nbits = 0;
        for (int i = 6; i >= 0; i--) begin e.bits = {e.bits[30:0], a[i]}; e.nbits++; end
        e.bits = {e.bits[30:0], r};     e.nbits++;
        e.bits = {e.bits[30:0], ~acka}; e.nbits++;
        if (acka) begin
            for (int i = 7; i >= 0; i--) begin
                e.bits = {e.bits[30:0], r ? rb[i] : d[i]};
                e.nbits++;
            end
            e.bits = {e.bits[30:0], r ? 1'b1 : ~ackd};
            e.nbits++;
        end
        e.bits = {e.bits[30:0], 1'b0};  // STOP: SCL rises with SDA still low
        e.nbits++;
        e.lat    = acka ? 40 : 24;
        e.ackerr = ~acka | (~r & ~ackd);
        if (acka && r) m_rdata = rb;
        e.rdata  = m_rdata;
        e.dseen  = acka;

        s_acka = acka; s_ackd = ackd; s_rw = r; s_rb = rb;
        q.push_back(e);

        @(negedge clk);
        start = 1'b1; addr = a; data = d; rw = r;
        @(negedge clk);
        start = 1'b0;
        addr = 7'($urandom); data = 8'($urandom); rw = 1'($urandom);
        if (mid) begin
            repeat ($urandom_range(1, 14)) @(negedge clk);
            start = 1'b1;
            addr = ~a; data = ~d; rw = ~r;
            @(negedge clk);
            start = 1'b0;
        end
        wait_ready();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; addr = '0; data = '0; rw = 1'b0;
        s_acka = 1'b0; s_ackd = 1'b0; s_rw = 1'b0; s_rb = '0;
        m_rdata = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_scl", {31'd0, scl}, 32'd1);
        check("reset_sda", {31'd0, sda}, 32'd1);
        check("reset_state", {24'd0, i2c.state}, 32'd0);
        rst = 1'b1;

        txn(7'h50, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        txn(7'h50, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
        txn(7'h50, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        txn(7'h2B, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);

        // Reset in the middle of the data byte.
        s_acka = 1'b1; s_ackd = 1'b1; s_rw = 1'b0; s_rb = '0;
        @(negedge clk);
        start = 1'b1; addr = 7'h11; data = 8'h0F; rw = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (i2c.state != 8'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_data_state", {24'd0, i2c.state}, 32'd5);
        #1;
        abort = 1'b1;
        rst = 1'b0;
        #1;
        check("midreset_state", {24'd0, i2c.state}, 32'd0);
        check("midreset_scl", {31'd0, scl}, 32'd1);
        check("midreset_sda", {31'd0, sda}, 32'd1);
        check("midreset_ready", {31'd0, ready}, 32'd1);
        check("midreset_ack_err", {31'd0, i2c.ack_err}, 32'd0);
        check("midreset_rdata", {24'd0, i2c.rdata}, 32'd0);
        m_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            txn(7'($urandom), 8'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                8'($urandom), 1'($urandom_range(0, 2) == 0));
        end

        repeat (10) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        check("bus_contention", contention, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
